// File: rtl/axi_round_clip_complex_buf.sv
// rtl/axi_round_clip_complex_buf.sv - buffered complex round-and-clip stage with AXI-Stream handshakes
//
// Purpose: register slice, then per-component round-half-up and saturation from
//          WIDTH_IN to WIDTH_OUT bits, then an optional first-word-fall-through
//          output FIFO of 2**FIFOSIZE entries (FIFOSIZE=0 means no FIFO).
// Ports:
//   clk, reset_n (async, active low), clear (sync flush, active high)
//   i_tdata {I,Q} / i_tlast / i_tvalid / i_tready : input stream
//   o_tdata {I,Q} / o_tlast / o_tvalid / o_tready : output stream
module axi_round_clip_complex_buf #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int CLIP_BITS = 1,
  parameter int FIFOSIZE  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [2*WIDTH_IN-1:0]  i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  output logic [2*WIDTH_OUT-1:0] o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready
);

  localparam int DROP = WIDTH_IN - WIDTH_OUT - CLIP_BITS;
  // Half an output LSB, at WIDTH_IN+1 bits so the add cannot wrap.
  localparam logic signed [WIDTH_IN:0] RND = {{WIDTH_IN{1'b0}}, 1'b1} << (DROP - 1);

  function automatic logic [WIDTH_OUT-1:0] round_clip(input logic [WIDTH_IN-1:0] x);
    logic signed [WIDTH_IN:0] sum;
    logic signed [WIDTH_IN:0] r;
    logic signed [WIDTH_IN:0] hi;
    logic signed [WIDTH_IN:0] lo;
    hi = '0;
    hi[WIDTH_OUT-2:0] = '1;
    lo = '1;
    lo[WIDTH_OUT-2:0] = '0;
    sum = $signed({x[WIDTH_IN-1], x}) + RND;
    r   = sum >>> DROP;
    if (r > hi)      return {1'b0, {(WIDTH_OUT-1){1'b1}}};
    else if (r < lo) return {1'b1, {(WIDTH_OUT-1){1'b0}}};
    else             return r[WIDTH_OUT-1:0];
  endfunction

  logic                   rdy_en;
  logic                   s1_valid;
  logic                   s1_last;
  logic [2*WIDTH_IN-1:0]  s1_data;
  logic                   s2_valid;
  logic                   s2_last;
  logic [2*WIDTH_OUT-1:0] s2_data;
  logic                   s1_load;
  logic                   s2_load;
  logic                   s2_ready;
  logic                   s2_unload;
  logic                   s3_ready;

  // rdy_en keeps i_tready low until the first edge after reset release.
  assign i_tready  = rdy_en & ~clear & (~s1_valid | s2_ready);
  assign s1_load   = i_tvalid & i_tready;
  assign s2_ready  = ~s2_valid | s3_ready;
  assign s2_load   = s1_valid & s2_ready;
  assign s2_unload = s2_valid & s3_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_last  <= i_tlast;
      s1_data  <= i_tdata;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_last  <= s1_last;
      s2_data  <= {round_clip(s1_data[2*WIDTH_IN-1:WIDTH_IN]), round_clip(s1_data[WIDTH_IN-1:0])};
    end else if (s2_unload) begin
      s2_valid <= 1'b0;
    end
  end

  generate
    if (FIFOSIZE == 0) begin : g_nofifo
      assign s3_ready = o_tready;
      assign o_tvalid = s2_valid;
      assign o_tdata  = s2_data;
      assign o_tlast  = s2_last;
    end else begin : g_fifo
      localparam int DEPTH = 2 ** FIFOSIZE;
      logic [2*WIDTH_OUT:0] mem [DEPTH];
      logic [FIFOSIZE-1:0]  wr_ptr;
      logic [FIFOSIZE-1:0]  rd_ptr;
      logic [FIFOSIZE:0]    count;
      logic                 pop;

      assign s3_ready = (count != (FIFOSIZE+1)'(DEPTH));
      assign pop      = o_tvalid & o_tready;
      assign o_tvalid = (count != '0);
      assign o_tdata  = mem[rd_ptr][2*WIDTH_OUT-1:0];
      assign o_tlast  = mem[rd_ptr][2*WIDTH_OUT];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (s2_unload) begin
            mem[wr_ptr] <= {s2_last, s2_data};
            wr_ptr      <= wr_ptr + 1'b1;
          end
          if (pop) rd_ptr <= rd_ptr + 1'b1;
          case ({s2_unload, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axi_round_clip_complex_buf.sv
// tb/tb_axi_round_clip_complex_buf.sv - directed self-checking bench for axi_round_clip_complex_buf
module tb_axi_round_clip_complex_buf;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [63:0] a_i_tdata, b_i_tdata;
  logic        a_i_tlast, b_i_tlast, a_i_tvalid, b_i_tvalid, a_i_tready, b_i_tready;
  logic [31:0] a_o_tdata, b_o_tdata;
  logic        a_o_tlast, b_o_tlast, a_o_tvalid, b_o_tvalid, a_o_tready, b_o_tready;

  int total = 0;
  int bad   = 0;

  logic [63:0] vin  [64];
  logic [31:0] vexp [64];
  logic        vlast[64];

  axi_round_clip_complex_buf dut_a (
    .clk(clk), .reset_n(rst_n), .clear(clear),
    .i_tdata(a_i_tdata), .i_tlast(a_i_tlast), .i_tvalid(a_i_tvalid), .i_tready(a_i_tready),
    .o_tdata(a_o_tdata), .o_tlast(a_o_tlast), .o_tvalid(a_o_tvalid), .o_tready(a_o_tready)
  );

  axi_round_clip_complex_buf #(.FIFOSIZE(3)) dut_b (
    .clk(clk), .reset_n(rst_n), .clear(clear),
    .i_tdata(b_i_tdata), .i_tlast(b_i_tlast), .i_tvalid(b_i_tvalid), .i_tready(b_i_tready),
    .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid), .o_tready(b_o_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Input components are exact multiples of 2**15, so they round to k and -k.
  function automatic logic [63:0] mkin(input int k);
    logic signed [31:0] v;
    v = k * 32768;
    return {v, -v};
  endfunction

  function automatic logic [31:0] mkexp(input int k);
    logic signed [15:0] e;
    e = 16'(k);
    return {e, -e};
  endfunction

  // Back-to-back beats into dut_a with o_tready=1; each output must appear exactly 2 cycles after acceptance.
  task automatic burst(input int n);
    a_o_tready = 1'b1;
    for (int t = 0; t < n + 2; t++) begin
      if (t < n) begin
        a_i_tvalid = 1'b1;
        a_i_tdata  = vin[t];
        a_i_tlast  = vlast[t];
      end else begin
        a_i_tvalid = 1'b0;
      end
      #1;
      if (t < n) chk("in_ready", a_i_tready, 1'b1);
      cyc();
      if (t == 0 || t - 1 >= n) begin
        chk("out_idle", a_o_tvalid, 1'b0);
      end else begin
        chk("out_valid", a_o_tvalid, 1'b1);
        chk("out_data", a_o_tdata, vexp[t-1]);
        chk("out_last", a_o_tlast, vlast[t-1]);
      end
    end
  endtask

  // Scoreboarded run with an o_tready=0 window [stall_lo, stall_hi); checks beats held at end of stall.
  task automatic sb_run(input bit use_b, input int n, input int stall_lo, input int stall_hi, input int exp_held);
    int nb;
    int ob;
    logic otr, itr, ov, ol, acc;
    logic [31:0] od;
    nb = 0;
    ob = 0;
    for (int t = 0; t < n + stall_hi + 10; t++) begin
      otr = !(t >= stall_lo && t < stall_hi);
      if (use_b) begin
        b_o_tready = otr; b_i_tvalid = (nb < n); b_i_tdata = mkin(nb + 1); b_i_tlast = (nb == n - 1);
      end else begin
        a_o_tready = otr; a_i_tvalid = (nb < n); a_i_tdata = mkin(nb + 1); a_i_tlast = (nb == n - 1);
      end
      #1;
      itr = use_b ? b_i_tready : a_i_tready;
      ov  = use_b ? b_o_tvalid : a_o_tvalid;
      od  = use_b ? b_o_tdata  : a_o_tdata;
      ol  = use_b ? b_o_tlast  : a_o_tlast;
      if (t == stall_hi - 1) begin
        chk("held_beats", 64'(nb - ob), 64'(exp_held));
        chk("stall_in_ready", itr, 1'b0);
      end
      if (ov && otr) begin
        chk("sb_data", od, mkexp(ob + 1));
        chk("sb_last", ol, (ob == n - 1));
        ob++;
      end
      acc = (nb < n) && itr;
      cyc();
      if (acc) nb++;
    end
    chk("sb_count", 64'(ob), 64'(n));
    a_i_tvalid = 1'b0; b_i_tvalid = 1'b0;
    a_o_tready = 1'b1; b_o_tready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    a_i_tdata = '0; a_i_tlast = 1'b0; a_i_tvalid = 1'b0; a_o_tready = 1'b1;
    b_i_tdata = '0; b_i_tlast = 1'b0; b_i_tvalid = 1'b0; b_o_tready = 1'b1;

    // Reset state
    #2;
    chk("rst_o_tvalid", a_o_tvalid, 1'b0);
    chk("rst_o_tdata", a_o_tdata, 32'h0);
    chk("rst_o_tlast", a_o_tlast, 1'b0);
    chk("rst_i_tready", a_i_tready, 1'b0);
    chk("rst_b_o_tdata", b_o_tdata, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("rel_i_tready_lo", a_i_tready, 1'b0);
    chk("rel_b_i_tready_lo", b_i_tready, 1'b0);
    cyc();
    chk("rel_i_tready_hi", a_i_tready, 1'b1);
    chk("rel_b_i_tready_hi", b_i_tready, 1'b1);

    // Rounding and saturation vectors
    vin[0] = 64'h00004000_FFFFBFFF; vexp[0] = 32'h0001_FFFF; vlast[0] = 1'b0;
    vin[1] = 64'h00003FFF_7FFFFFFF; vexp[1] = 32'h0000_7FFF; vlast[1] = 1'b0;
    vin[2] = 64'hFFFFC000_80000000; vexp[2] = 32'h0000_8000; vlast[2] = 1'b0;
    vin[3] = 64'h3FFF8000_40000000; vexp[3] = 32'h7FFF_7FFF; vlast[3] = 1'b0;
    vin[4] = 64'h80000000_00000000; vexp[4] = 32'h8000_0000; vlast[4] = 1'b1;
    burst(5);

    // 64-beat stream, tlast only on the last beat
    for (int j = 0; j < 64; j++) begin
      vin[j] = mkin(j - 20); vexp[j] = mkexp(j - 20); vlast[j] = (j == 63);
    end
    burst(64);

    // Backpressure mid-packet on the unbuffered instance
    sb_run(1'b0, 20, 6, 16, 2);

    // Clear with two beats held
    a_o_tready = 1'b0;
    a_i_tvalid = 1'b1; a_i_tdata = mkin(50); a_i_tlast = 1'b0;
    cyc();
    a_i_tdata = mkin(51);
    cyc();
    a_i_tvalid = 1'b0;
    chk("pre_clear_valid", a_o_tvalid, 1'b1);
    chk("pre_clear_data", a_o_tdata, mkexp(50));
    clear = 1'b1;
    a_i_tvalid = 1'b1; a_i_tdata = mkin(52); a_i_tlast = 1'b1;
    #1;
    chk("clear_i_tready", a_i_tready, 1'b0);
    cyc();
    clear = 1'b0;
    a_i_tvalid = 1'b0;
    chk("post_clear_valid", a_o_tvalid, 1'b0);
    a_o_tready = 1'b1;
    cyc(); cyc();
    chk("post_clear_idle", a_o_tvalid, 1'b0);
    vin[0] = mkin(7); vexp[0] = mkexp(7); vlast[0] = 1'b1;
    burst(1);

    // Asynchronous reset mid-packet
    a_i_tvalid = 1'b1; a_i_tdata = mkin(3); a_i_tlast = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_rst_valid", a_o_tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", a_o_tvalid, 1'b0);
    chk("async_rst_data", a_o_tdata, 32'h0);
    chk("async_rst_ready", a_i_tready, 1'b0);
    a_i_tvalid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst2_i_tready", a_i_tready, 1'b1);

    // FIFOSIZE=3: 10 beats absorbed under backpressure, then drained in order
    sb_run(1'b1, 12, 0, 15, 10);

    // FIFOSIZE=3 latency: output appears 3 cycles after acceptance
    b_o_tready = 1'b1;
    b_i_tvalid = 1'b1; b_i_tdata = mkin(9); b_i_tlast = 1'b1;
    #1;
    chk("b_lat_in_ready", b_i_tready, 1'b1);
    cyc();
    b_i_tvalid = 1'b0;
    chk("b_lat_c1", b_o_tvalid, 1'b0);
    cyc();
    chk("b_lat_c2", b_o_tvalid, 1'b0);
    cyc();
    chk("b_lat_c3", b_o_tvalid, 1'b1);
    chk("b_lat_data", b_o_tdata, mkexp(9));
    chk("b_lat_last", b_o_tlast, 1'b1);
    cyc();
    chk("b_lat_c4", b_o_tvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
